// File: rtl/beam_buf_ctrl_pkg.sv
// Shared types and constants for the 4-block beam buffer controller.
package beam_buf_ctrl_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WR,
    S_GAP,
    S_RD
  } state_t;

  localparam int NUM_BLK    = 4;
  localparam int DEF_RD_LAT = 3;

endpackage

// File: rtl/beam_buf_ctrl_delay_line.sv
// Fixed-depth shift register used to align read side-band with buffer data.
module bbc_delay_line #(
  parameter int DEPTH = 3,
  parameter int WIDTH = 1
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic [WIDTH-1:0] i_din,
  output logic [WIDTH-1:0] o_dout
);

  logic [DEPTH-1:0][WIDTH-1:0] vld_pipe;

  // Shift one stage per cycle; reset flushes everything in flight.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      vld_pipe <= '0;
    end else begin
      vld_pipe[0] <= i_din;
      for (int i = 1; i < DEPTH; i++) vld_pipe[i] <= vld_pipe[i-1];
    end
  end

  assign o_dout = vld_pipe[DEPTH-1];

endmodule

// File: rtl/beam_buf_ctrl.sv
// Beam buffer controller: writes four upstream bursts into four buffer
// blocks, then reads the frame back using block 0's length.
module beam_buf_ctrl
  import beam_buf_ctrl_pkg::*;
#(
  parameter int WADDR_WIDTH = 11,
  parameter int BLK_LEN     = 1024,
  parameter int RD_LAT      = DEF_RD_LAT
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  input  logic                   i_blk_vld,
  input  logic                   i_rd_ready,
  output logic [NUM_BLK-1:0]     o_wr_wen,
  output logic [WADDR_WIDTH-1:0] o_wr_addr,
  output logic                   o_rd_ren,
  output logic [WADDR_WIDTH-1:0] o_rd_addr,
  output logic                   o_rd_vld,
  output logic                   o_rd_sop,
  output logic                   o_rd_eop,
  output logic [1:0]             o_blk_idx,
  output logic                   o_busy,
  output logic                   o_ovf,
  output logic                   o_len_err
);

  // Word counters need one extra bit: a full block holds 2^WADDR_WIDTH words.
  localparam int                     CW        = WADDR_WIDTH + 1;
  localparam logic [CW-1:0]          BLK_LEN_C = CW'(BLK_LEN);
  localparam logic [WADDR_WIDTH-1:0] LAST_A    = WADDR_WIDTH'(BLK_LEN - 1);

  state_t                 state, nxt;
  logic [1:0]             blk_idx;
  logic [CW-1:0]          wcnt, l0;
  logic [WADDR_WIDTH-1:0] rd_cnt;
  logic                   accept, fall, rd_last, rd_fin, drop_rd;
  logic                   rd_ren, rd_sop, rd_eop;
  logic [2:0]             dly_out;

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_reset) state <= S_IDLE;
    else         state <= nxt;
  end

  // Next state plus per-cycle write/read decisions.
  always_comb begin
    nxt     = state;
    o_busy  = (state != S_IDLE);
    accept  = 1'b0;
    fall    = 1'b0;
    rd_ren  = 1'b0;
    rd_fin  = 1'b0;
    drop_rd = 1'b0;
    rd_last = ({1'b0, rd_cnt} == l0 - CW'(1));
    case (state)
      S_IDLE, S_GAP: begin
        accept = i_blk_vld;
        if (i_blk_vld) nxt = S_WR;
      end
      S_WR: begin
        if (i_blk_vld) begin
          accept = 1'b1;
        end else begin
          fall = 1'b1;
          nxt  = (blk_idx == 2'(NUM_BLK - 1)) ? S_RD : S_GAP;
        end
      end
      S_RD: begin
        rd_ren = i_rd_ready;
        rd_fin = i_rd_ready && rd_last;
        // A burst starting on the final read cycle is taken, not dropped.
        if (rd_fin) begin
          accept = i_blk_vld;
          nxt    = i_blk_vld ? S_WR : S_IDLE;
        end else begin
          drop_rd = i_blk_vld;
        end
      end
      default: nxt = S_IDLE;
    endcase
    rd_sop = rd_ren && (rd_cnt == '0);
    rd_eop = rd_ren && rd_last;
  end

  // Write path, block bookkeeping, read address and sticky error flags.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_wr_wen  <= '0;
      o_wr_addr <= '0;
      wcnt      <= '0;
      l0        <= '0;
      blk_idx   <= '0;
      rd_cnt    <= '0;
      o_ovf     <= 1'b0;
      o_len_err <= 1'b0;
    end else begin
      o_wr_wen <= '0;
      if (accept) begin
        if (wcnt < BLK_LEN_C) begin
          o_wr_wen  <= NUM_BLK'(1) << blk_idx;
          o_wr_addr <= wcnt[WADDR_WIDTH-1:0];
          wcnt      <= wcnt + CW'(1);
        end else begin
          o_wr_addr <= LAST_A;
          o_ovf     <= 1'b1;
        end
      end
      if (fall) begin
        wcnt    <= '0;
        blk_idx <= blk_idx + 2'd1;
        if (blk_idx == 2'd0)  l0        <= wcnt;
        else if (wcnt != l0)  o_len_err <= 1'b1;
      end
      if (drop_rd) o_ovf <= 1'b1;
      if (rd_ren)  rd_cnt <= rd_last ? '0 : rd_cnt + WADDR_WIDTH'(1);
    end
  end

  bbc_delay_line #(
    .DEPTH (RD_LAT),
    .WIDTH (3)
  ) u_dly (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_din   ({rd_ren, rd_sop, rd_eop}),
    .o_dout  (dly_out)
  );

  assign o_rd_vld  = dly_out[2];
  assign o_rd_sop  = dly_out[1];
  assign o_rd_eop  = dly_out[0];
  assign o_rd_ren  = rd_ren;
  assign o_rd_addr = rd_cnt;
  assign o_blk_idx = blk_idx;

endmodule

// File: tb/tb_beam_buf_ctrl.sv
// Scoreboard bench for beam_buf_ctrl: expected writes/reads are queued as
// stimulus is driven and popped as the DUT produces them.
module tb_beam_buf_ctrl;
  import beam_buf_ctrl_pkg::*;

  localparam int WAW = 11;
  localparam int RDL = 3;

  logic           i_clk = 1'b0, i_reset = 1'b1, i_blk_vld = 1'b0, i_rd_ready = 1'b0;
  logic [3:0]     o_wr_wen;
  logic [WAW-1:0] o_wr_addr, o_rd_addr;
  logic           o_rd_ren, o_rd_vld, o_rd_sop, o_rd_eop, o_busy, o_ovf, o_len_err;
  logic [1:0]     o_blk_idx;

  // Second instance with a 4-word block limit for the overflow scenario.
  logic [3:0]     wen_4;
  logic [WAW-1:0] wr_addr_4, rd_addr_4;
  logic           rd_ren_4, rd_vld_4, rd_sop_4, rd_eop_4, busy_4, ovf_4, len_err_4;
  logic [1:0]     blk_idx_4;

  beam_buf_ctrl u_dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_blk_vld(i_blk_vld), .i_rd_ready(i_rd_ready),
    .o_wr_wen(o_wr_wen), .o_wr_addr(o_wr_addr), .o_rd_ren(o_rd_ren), .o_rd_addr(o_rd_addr),
    .o_rd_vld(o_rd_vld), .o_rd_sop(o_rd_sop), .o_rd_eop(o_rd_eop), .o_blk_idx(o_blk_idx),
    .o_busy(o_busy), .o_ovf(o_ovf), .o_len_err(o_len_err)
  );

  beam_buf_ctrl #(.WADDR_WIDTH(WAW), .BLK_LEN(4), .RD_LAT(RDL)) u_dut4 (
    .i_clk(i_clk), .i_reset(i_reset), .i_blk_vld(i_blk_vld), .i_rd_ready(i_rd_ready),
    .o_wr_wen(wen_4), .o_wr_addr(wr_addr_4), .o_rd_ren(rd_ren_4), .o_rd_addr(rd_addr_4),
    .o_rd_vld(rd_vld_4), .o_rd_sop(rd_sop_4), .o_rd_eop(rd_eop_4), .o_blk_idx(blk_idx_4),
    .o_busy(busy_4), .o_ovf(ovf_4), .o_len_err(len_err_4)
  );

  always #5 i_clk = ~i_clk;

  typedef struct { logic [3:0] wen; logic [WAW-1:0] addr; } wr_t;
  typedef struct { logic [WAW-1:0] addr; logic sop; logic eop; } rd_t;
  typedef struct { int t; logic sop; logic eop; } vl_t;

  wr_t wq[$];
  rd_t rq[$];
  vl_t vq[$];
  int  checks = 0, passes = 0, cyc = 0, wr4_cnt = 0;

  always @(posedge i_clk) cyc <= cyc + 1;

  // Monitor: pop expectations whenever the DUT writes, reads or returns data.
  always @(negedge i_clk) begin
    wr_t ew;
    rd_t er;
    vl_t ev;
    if (o_wr_wen !== 4'b0) begin
      checks++;
      if (wq.size() == 0) begin
        $display("FAIL wr_extra: got wen=%b addr=%0d, expected no write", o_wr_wen, o_wr_addr);
      end else begin
        ew = wq.pop_front();
        if (o_wr_wen !== ew.wen || o_wr_addr !== ew.addr)
          $display("FAIL wr_seq: got wen=%b addr=%0d, expected wen=%b addr=%0d",
                   o_wr_wen, o_wr_addr, ew.wen, ew.addr);
        else passes++;
      end
    end
    if (o_rd_ren !== 1'b0) begin
      checks++;
      if (rq.size() == 0) begin
        $display("FAIL rd_extra: got ren at addr=%0d, expected no read", o_rd_addr);
      end else begin
        er = rq.pop_front();
        vq.push_back('{cyc + RDL, er.sop, er.eop});
        if (o_rd_addr !== er.addr || i_rd_ready !== 1'b1)
          $display("FAIL rd_seq: got addr=%0d ready=%b, expected addr=%0d ready=1",
                   o_rd_addr, i_rd_ready, er.addr);
        else passes++;
      end
    end
    if (o_rd_vld !== 1'b0) begin
      checks++;
      if (vq.size() == 0) begin
        $display("FAIL vld_extra: got rd_vld at cycle %0d, expected none", cyc);
      end else begin
        ev = vq.pop_front();
        if (cyc != ev.t || o_rd_sop !== ev.sop || o_rd_eop !== ev.eop)
          $display("FAIL vld_seq: got cyc=%0d sop=%b eop=%b, expected cyc=%0d sop=%b eop=%b",
                   cyc, o_rd_sop, o_rd_eop, ev.t, ev.sop, ev.eop);
        else passes++;
      end
    end
    if (wen_4 !== 4'b0) wr4_cnt++;
  end

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic do_reset();
    i_reset = 1'b1; i_blk_vld = 1'b0; i_rd_ready = 1'b0;
    tick(); tick();
    i_reset = 1'b0;
    wq.delete(); rq.delete(); vq.delete();
  endtask

  // Queue the expected writes for one burst, then drive it plus a low cycle.
  task automatic send_blk(input int b, input int n);
    wr_t w;
    for (int i = 0; i < n; i++) begin
      w.wen  = 4'(1 << b);
      w.addr = WAW'(i);
      wq.push_back(w);
    end
    for (int i = 0; i < n; i++) begin
      i_blk_vld = 1'b1;
      tick();
    end
    i_blk_vld = 1'b0;
    tick();
  endtask

  task automatic push_rd(input int len);
    rd_t r;
    for (int i = 0; i < len; i++) begin
      r.addr = WAW'(i);
      r.sop  = (i == 0);
      r.eop  = (i == len - 1);
      rq.push_back(r);
    end
  endtask

  task automatic drain(input string name);
    int k = 0;
    while ((wq.size() != 0 || rq.size() != 0 || vq.size() != 0 || o_busy !== 1'b0) && k < 300) begin
      tick();
      k++;
    end
    repeat (RDL + 2) tick();
    checks++;
    if (k >= 300)
      $display("FAIL %s_drain: got wq=%0d rq=%0d vq=%0d busy=%b, expected all empty and idle",
               name, wq.size(), rq.size(), vq.size(), o_busy);
    else passes++;
  endtask

  task automatic test_reset();
    i_reset = 1'b1;
    tick(); tick();
    checks++;
    if ({o_wr_wen, o_wr_addr, o_rd_ren, o_rd_addr, o_rd_vld, o_rd_sop, o_rd_eop} !== '0)
      $display("FAIL reset_data: got wen=%b waddr=%0d ren=%b raddr=%0d vld=%b, expected 0",
               o_wr_wen, o_wr_addr, o_rd_ren, o_rd_addr, o_rd_vld);
    else passes++;
    checks++;
    if ({o_blk_idx, o_busy, o_ovf, o_len_err} !== 5'b0)
      $display("FAIL reset_status: got idx=%0d busy=%b ovf=%b len_err=%b, expected 0",
               o_blk_idx, o_busy, o_ovf, o_len_err);
    else passes++;
    i_reset = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    do_reset();
    i_rd_ready = 1'b1;
    push_rd(8);
    for (int b = 0; b < 4; b++) send_blk(b, 8);
    drain("basic");
    checks++;
    if (o_ovf !== 1'b0 || o_len_err !== 1'b0)
      $display("FAIL basic_flags: got ovf=%b len_err=%b, expected 0 0", o_ovf, o_len_err);
    else passes++;
  endtask

  task automatic test_len_err();
    do_reset();
    i_rd_ready = 1'b1;
    push_rd(8);
    send_blk(0, 8); send_blk(1, 8); send_blk(2, 6); send_blk(3, 8);
    drain("len_err");
    checks++;
    if (o_len_err !== 1'b1 || o_ovf !== 1'b0)
      $display("FAIL len_err_flag: got len_err=%b ovf=%b, expected 1 0", o_len_err, o_ovf);
    else passes++;
  endtask

  task automatic test_stall();
    do_reset();
    push_rd(8);
    for (int b = 0; b < 4; b++) send_blk(b, 8);
    for (int k = 0; k < 40 && rq.size() != 0; k++) begin
      i_rd_ready = (k % 2 == 0);
      tick();
    end
    i_rd_ready = 1'b1;
    drain("stall");
  endtask

  task automatic test_len1();
    do_reset();
    i_rd_ready = 1'b1;
    push_rd(1);
    for (int b = 0; b < 4; b++) send_blk(b, 1);
    drain("len1");
    checks++;
    if (o_len_err !== 1'b0)
      $display("FAIL len1_flag: got len_err=%b, expected 0", o_len_err);
    else passes++;
  endtask

  task automatic test_ovf_len();
    do_reset();
    wr4_cnt = 0;
    send_blk(0, 6);
    tick();
    checks++;
    if (wr4_cnt != 4 || wr_addr_4 !== WAW'(3) || ovf_4 !== 1'b1)
      $display("FAIL ovf_blk_len: got writes=%0d addr=%0d ovf=%b, expected 4 3 1",
               wr4_cnt, wr_addr_4, ovf_4);
    else passes++;
    checks++;
    if (o_ovf !== 1'b0 || wq.size() != 0)
      $display("FAIL ovf_big_blk: got ovf=%b pending=%0d, expected 0 0", o_ovf, wq.size());
    else passes++;
  endtask

  task automatic test_rd_drop();
    do_reset();
    i_rd_ready = 1'b1;
    push_rd(8);
    for (int b = 0; b < 4; b++) send_blk(b, 8);
    // First RD cycle now; reads issue on this and the next seven cycles.
    tick(); tick();
    i_blk_vld = 1'b1;
    tick(); tick();
    i_blk_vld = 1'b0;
    tick(); tick(); tick();
    // Final read issues this cycle: a new burst starting here is kept.
    send_blk(0, 8);
    repeat (RDL + 2) tick();
    checks++;
    if (o_ovf !== 1'b1 || o_busy !== 1'b1 || o_blk_idx !== 2'd1)
      $display("FAIL rd_drop_state: got ovf=%b busy=%b idx=%0d, expected 1 1 1",
               o_ovf, o_busy, o_blk_idx);
    else passes++;
    checks++;
    if (wq.size() != 0 || rq.size() != 0 || vq.size() != 0)
      $display("FAIL rd_drop_pending: got wq=%0d rq=%0d vq=%0d, expected 0 0 0",
               wq.size(), rq.size(), vq.size());
    else passes++;
  endtask

  task automatic test_reset_mid();
    wr_t w;
    do_reset();
    i_rd_ready = 1'b1;
    send_blk(0, 8); send_blk(1, 8);
    for (int i = 0; i < 3; i++) begin
      w.wen = 4'b0100; w.addr = WAW'(i);
      wq.push_back(w);
    end
    i_blk_vld = 1'b1;
    tick(); tick(); tick();
    i_blk_vld = 1'b0; i_reset = 1'b1;
    tick();
    i_reset = 1'b0;
    checks++;
    if ({o_wr_wen, o_wr_addr, o_rd_ren, o_rd_addr, o_rd_vld, o_rd_sop, o_rd_eop,
         o_blk_idx, o_busy, o_ovf, o_len_err} !== '0)
      $display("FAIL reset_mid_outs: got wen=%b waddr=%0d idx=%0d busy=%b, expected all 0",
               o_wr_wen, o_wr_addr, o_blk_idx, o_busy);
    else passes++;
    checks++;
    if (wq.size() != 0)
      $display("FAIL reset_mid_writes: got %0d pending writes, expected 0", wq.size());
    else passes++;
    push_rd(8);
    for (int b = 0; b < 4; b++) send_blk(b, 8);
    drain("reset_mid");
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_basic();
    test_len_err();
    test_stall();
    test_len1();
    test_ovf_len();
    test_rd_drop();
    test_reset_mid();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
